// File: rtl/ibus_responder_if.sv
// Instruction-bus bundle between the fetch stage, ibus_responder and the memory port.
// slave: responder view. master: fetch stage and memory model view.
interface ibus_responder_if #(
  parameter int unsigned MEM_ADDR_W = 32
) ();
  logic                  ireq_valid;
  logic [MEM_ADDR_W-1:0] ireq_addr;
  logic                  iresp_addr_ok;
  logic                  iresp_data_ok;
  logic [31:0]           iresp_data;
  logic                  iresp_err;
  logic                  mem_req_valid;
  logic [MEM_ADDR_W-1:0] mem_req_addr;
  logic                  mem_resp_ready;
  logic [31:0]           mem_resp_data;

  modport slave (
    input  ireq_valid, ireq_addr, mem_resp_ready, mem_resp_data,
    output iresp_addr_ok, iresp_data_ok, iresp_data, iresp_err, mem_req_valid, mem_req_addr
  );

  modport master (
    output ireq_valid, ireq_addr, mem_resp_ready, mem_resp_data,
    input  iresp_addr_ok, iresp_data_ok, iresp_data, iresp_err, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/ibus_responder.sv
// Single-outstanding ibus responder: one single-beat memory read per fetch request.
// Define IBUS_PREFETCH_EN to add a one-entry next-word prefetch buffer.
module ibus_responder #(
  parameter int unsigned MEM_ADDR_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  ibus_responder_if.slave  bus
);

`ifdef IBUS_PREFETCH_EN
  typedef enum logic [1:0] {StIdle, StFetch, StDone, StPrefetch} state_e;
`else
  typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;
`endif

  state_e                r_state, w_state_d;
  logic                  r_mem_req_valid, w_mem_req_valid_d;
  logic [MEM_ADDR_W-1:0] r_mem_req_addr, w_mem_req_addr_d;
  logic [31:0]           r_data, w_data_d;
  logic                  r_err, w_err_d;

`ifdef IBUS_PREFETCH_EN
  logic [MEM_ADDR_W-1:0] r_req_addr, w_req_addr_d;
  logic                  r_pf_valid, w_pf_valid_d;
  logic [MEM_ADDR_W-1:0] r_pf_addr, w_pf_addr_d;
  logic [31:0]           r_pf_data, w_pf_data_d;
`endif

  logic w_addr_ok;
  logic w_hs;
  logic w_misaligned;
  logic w_data_ok;

  // Gated with resetn so addr_ok reads 0 while reset is held, even in StIdle.
  assign w_addr_ok    = resetn & (r_state == StIdle) & bus.ireq_valid;
  assign w_hs         = bus.ireq_valid & w_addr_ok;
  assign w_misaligned = (bus.ireq_addr[1:0] != 2'b00);
  assign w_data_ok    = (r_state == StDone);

  always_comb begin
    w_state_d         = r_state;
    w_mem_req_valid_d = r_mem_req_valid;
    w_mem_req_addr_d  = r_mem_req_addr;
    w_data_d          = r_data;
    w_err_d           = r_err;
`ifdef IBUS_PREFETCH_EN
    w_req_addr_d      = r_req_addr;
    w_pf_valid_d      = r_pf_valid;
    w_pf_addr_d       = r_pf_addr;
    w_pf_data_d       = r_pf_data;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_hs) begin
`ifdef IBUS_PREFETCH_EN
          w_req_addr_d = bus.ireq_addr;
          w_pf_valid_d = 1'b0;
`endif
          if (w_misaligned) begin
            w_data_d  = 32'h0;
            w_err_d   = 1'b1;
            w_state_d = StDone;
`ifdef IBUS_PREFETCH_EN
          end else if (r_pf_valid && (bus.ireq_addr == r_pf_addr)) begin
            w_data_d  = r_pf_data;
            w_err_d   = 1'b0;
            w_state_d = StDone;
`endif
          end else begin
            w_err_d           = 1'b0;
            w_mem_req_valid_d = 1'b1;
            w_mem_req_addr_d  = {bus.ireq_addr[MEM_ADDR_W-1:2], 2'b00};
            w_state_d         = StFetch;
          end
        end
      end
      StFetch: begin
        if (bus.mem_resp_ready) begin
          w_data_d          = bus.mem_resp_data;
          w_mem_req_valid_d = 1'b0;
          w_state_d         = StDone;
        end
      end
      StDone: begin
`ifdef IBUS_PREFETCH_EN
        if (!r_err) begin
          w_mem_req_valid_d = 1'b1;
          w_mem_req_addr_d  = r_req_addr + MEM_ADDR_W'(4);
          w_state_d         = StPrefetch;
        end else begin
          w_state_d = StIdle;
        end
`else
        w_state_d = StIdle;
`endif
      end
`ifdef IBUS_PREFETCH_EN
      StPrefetch: begin
        if (bus.mem_resp_ready) begin
          w_pf_data_d       = bus.mem_resp_data;
          w_pf_addr_d       = r_mem_req_addr;
          w_pf_valid_d      = 1'b1;
          w_mem_req_valid_d = 1'b0;
          w_state_d         = StIdle;
        end
      end
`endif
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state         <= StIdle;
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= '0;
      r_data          <= 32'h0;
      r_err           <= 1'b0;
`ifdef IBUS_PREFETCH_EN
      r_req_addr      <= '0;
      r_pf_valid      <= 1'b0;
      r_pf_addr       <= '0;
      r_pf_data       <= 32'h0;
`endif
    end else begin
      r_state         <= w_state_d;
      r_mem_req_valid <= w_mem_req_valid_d;
      r_mem_req_addr  <= w_mem_req_addr_d;
      r_data          <= w_data_d;
      r_err           <= w_err_d;
`ifdef IBUS_PREFETCH_EN
      r_req_addr      <= w_req_addr_d;
      r_pf_valid      <= w_pf_valid_d;
      r_pf_addr       <= w_pf_addr_d;
      r_pf_data       <= w_pf_data_d;
`endif
    end
  end

  assign bus.iresp_addr_ok = w_addr_ok;
  assign bus.iresp_data_ok = w_data_ok;
  assign bus.iresp_data    = w_data_ok ? r_data : 32'h0;
  assign bus.iresp_err     = w_data_ok & r_err;
  assign bus.mem_req_valid = r_mem_req_valid;
  assign bus.mem_req_addr  = r_mem_req_addr;

endmodule

// File: tb/tb_ibus_responder.sv
// Directed self-checking bench for ibus_responder; follows IBUS_PREFETCH_EN if defined.
module tb_ibus_responder;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  ibus_responder_if #(.MEM_ADDR_W(32)) bus ();

  ibus_responder #(.MEM_ADDR_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset held with a pending request; all outputs must stay low.
    bus.ireq_valid     = 1'b1;
`ifdef IBUS_PREFETCH_EN
    bus.ireq_addr      = 32'h0000_1000;
`else
    bus.ireq_addr      = 32'hBFC0_0000;
`endif
    bus.mem_resp_ready = 1'b0;
    bus.mem_resp_data  = 32'h0;
    resetn             = 1'b0;
    repeat (2) tick();
    #2;
    check("rst_addr_ok", {31'h0, bus.iresp_addr_ok}, 32'h0);
    check("rst_data_ok", {31'h0, bus.iresp_data_ok}, 32'h0);
    check("rst_mem_req_valid", {31'h0, bus.mem_req_valid}, 32'h0);
    check("rst_mem_req_addr", bus.mem_req_addr, 32'h0);
    check("rst_iresp_data", bus.iresp_data, 32'h0);
    resetn = 1'b1;
    #1;
    check("rel_addr_ok", {31'h0, bus.iresp_addr_ok}, 32'h1);

`ifdef IBUS_PREFETCH_EN
    // Cycle 0 was the handshake for 0x1000; memory answers 1 cycle after each request.
    tick(); bus.ireq_valid = 1'b0; bus.mem_resp_ready = 1'b1; bus.mem_resp_data = 32'hAAAA_1000;
    #2;
    check("pf_fetch_valid", {31'h0, bus.mem_req_valid}, 32'h1);
    check("pf_fetch_addr", bus.mem_req_addr, 32'h0000_1000);
    tick(); bus.mem_resp_ready = 1'b0;
    #2;
    check("pf_d0_ok", {31'h0, bus.iresp_data_ok}, 32'h1);
    check("pf_d0_data", bus.iresp_data, 32'hAAAA_1000);
    tick(); bus.mem_resp_ready = 1'b1; bus.mem_resp_data = 32'hBBBB_1004;
    bus.ireq_valid = 1'b1; bus.ireq_addr = 32'h0000_1004;
    #2;
    check("pf_req_valid", {31'h0, bus.mem_req_valid}, 32'h1);
    check("pf_req_addr", bus.mem_req_addr, 32'h0000_1004);
    check("pf_busy_addr_ok", {31'h0, bus.iresp_addr_ok}, 32'h0);
    tick(); bus.mem_resp_ready = 1'b0;
    #2;
    check("hit_addr_ok", {31'h0, bus.iresp_addr_ok}, 32'h1);
    tick(); bus.ireq_valid = 1'b0;
    #2;
    check("hit_data_ok", {31'h0, bus.iresp_data_ok}, 32'h1);
    check("hit_data", bus.iresp_data, 32'hBBBB_1004);
    check("hit_no_mem_req", {31'h0, bus.mem_req_valid}, 32'h0);
    tick(); bus.mem_resp_ready = 1'b1; bus.mem_resp_data = 32'hCCCC_1008;
    #2;
    check("pf2_req_addr", bus.mem_req_addr, 32'h0000_1008);
    tick(); bus.mem_resp_ready = 1'b0; bus.ireq_valid = 1'b1; bus.ireq_addr = 32'h0000_2000;
    #2;
    check("miss_addr_ok", {31'h0, bus.iresp_addr_ok}, 32'h1);
    tick(); bus.ireq_valid = 1'b0; bus.mem_resp_ready = 1'b1; bus.mem_resp_data = 32'hDDDD_2000;
    #2;
    check("miss_req_valid", {31'h0, bus.mem_req_valid}, 32'h1);
    check("miss_req_addr", bus.mem_req_addr, 32'h0000_2000);
    check("miss_no_early_ok", {31'h0, bus.iresp_data_ok}, 32'h0);
    tick(); bus.mem_resp_ready = 1'b0;
    #2;
    check("miss_data", bus.iresp_data, 32'hDDDD_2000);
    tick(); bus.mem_resp_ready = 1'b1; bus.mem_resp_data = 32'hEEEE_2004;
    #2;
    check("pf3_req_addr", bus.mem_req_addr, 32'h0000_2004);
    // 0x1008 was dropped by the miss, so it must be fetched from memory.
    tick(); bus.mem_resp_ready = 1'b0; bus.ireq_valid = 1'b1; bus.ireq_addr = 32'h0000_1008;
    #2;
    check("stale_addr_ok", {31'h0, bus.iresp_addr_ok}, 32'h1);
    tick(); bus.ireq_valid = 1'b0; bus.mem_resp_ready = 1'b1; bus.mem_resp_data = 32'h1234_5678;
    #2;
    check("stale_refetch_valid", {31'h0, bus.mem_req_valid}, 32'h1);
    check("stale_refetch_addr", bus.mem_req_addr, 32'h0000_1008);
    check("stale_no_data_ok", {31'h0, bus.iresp_data_ok}, 32'h0);
`else
    // Cycle 0 was the handshake for 0xBFC00000; memory ready in cycle 3.
    // The next (misaligned) request is held pending to probe addr_ok.
    for (int c = 1; c <= 4; c++) begin
      tick();
      bus.ireq_addr      = 32'h0000_0402;
      bus.mem_resp_ready = (c == 3);
      bus.mem_resp_data  = 32'h3C08_BFC0;
      #2;
      check($sformatf("miss_c%0d_addr_ok", c), {31'h0, bus.iresp_addr_ok}, 32'h0);
      check($sformatf("miss_c%0d_data_ok", c), {31'h0, bus.iresp_data_ok}, {31'h0, c == 4});
      check($sformatf("miss_c%0d_data", c), bus.iresp_data, (c == 4) ? 32'h3C08_BFC0 : 32'h0);
      if (c <= 3) begin
        check($sformatf("miss_c%0d_req_valid", c), {31'h0, bus.mem_req_valid}, 32'h1);
        check($sformatf("miss_c%0d_req_addr", c), bus.mem_req_addr, 32'hBFC0_0000);
      end
    end
    tick(); bus.mem_resp_ready = 1'b0;
    #2;
    check("mis_addr_ok", {31'h0, bus.iresp_addr_ok}, 32'h1);
    tick(); bus.ireq_valid = 1'b0;
    #2;
    check("mis_data_ok", {31'h0, bus.iresp_data_ok}, 32'h1);
    check("mis_err", {31'h0, bus.iresp_err}, 32'h1);
    check("mis_data", bus.iresp_data, 32'h0);
    check("mis_no_mem_req", {31'h0, bus.mem_req_valid}, 32'h0);
    tick();
    #2;
    check("mis_after_data_ok", {31'h0, bus.iresp_data_ok}, 32'h0);
    check("mis_after_err", {31'h0, bus.iresp_err}, 32'h0);
    check("mis_after_mem_req", {31'h0, bus.mem_req_valid}, 32'h0);

    // Back-to-back at 0x0/0x4/0x8 with ready held high (also while no request is pending).
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      bus.ireq_valid     = 1'b1;
      bus.ireq_addr      = 32'(4 * (i / 3));
      bus.mem_resp_ready = 1'b1;
      bus.mem_resp_data  = 32'h1111_0000 + 32'(4 * (i / 3));
      #2;
      check($sformatf("b2b_c%0d_addr_ok", i), {31'h0, bus.iresp_addr_ok}, {31'h0, (i % 3) == 0});
      check($sformatf("b2b_c%0d_data_ok", i), {31'h0, bus.iresp_data_ok}, {31'h0, (i % 3) == 2});
      if ((i % 3) == 2)
        check($sformatf("b2b_c%0d_data", i), bus.iresp_data, 32'h1111_0000 + 32'(4 * (i / 3)));
      if ((i % 3) == 1)
        check($sformatf("b2b_c%0d_req_addr", i), bus.mem_req_addr, 32'(4 * (i / 3)));
    end

    // Reset asserted in FETCH cycle 2, then a clean request at 0x100.
    tick(); bus.mem_resp_ready = 1'b0; bus.ireq_addr = 32'h0000_0200;
    #2;
    check("rf_hs", {31'h0, bus.iresp_addr_ok}, 32'h1);
    tick(); bus.ireq_valid = 1'b0;
    tick();
    #2;
    check("rf_req_before", {31'h0, bus.mem_req_valid}, 32'h1);
    resetn = 1'b0;
    #1;
    check("rf_req_dropped", {31'h0, bus.mem_req_valid}, 32'h0);
    check("rf_req_addr_clr", bus.mem_req_addr, 32'h0);
    tick(); resetn = 1'b1;
    #2;
    check("rf_no_stale_ok0", {31'h0, bus.iresp_data_ok}, 32'h0);
    tick();
    #2;
    check("rf_no_stale_ok1", {31'h0, bus.iresp_data_ok}, 32'h0);
    bus.ireq_valid = 1'b1; bus.ireq_addr = 32'h0000_0100; bus.mem_resp_data = 32'hDEAD_BEEF;
    #1;
    check("rf_new_hs", {31'h0, bus.iresp_addr_ok}, 32'h1);
    tick(); bus.ireq_valid = 1'b0; bus.mem_resp_ready = 1'b1;
    #2;
    check("rf_new_req_addr", bus.mem_req_addr, 32'h0000_0100);
    check("rf_new_no_early", {31'h0, bus.iresp_data_ok}, 32'h0);
    tick(); bus.mem_resp_ready = 1'b0;
    #2;
    check("rf_new_data_ok", {31'h0, bus.iresp_data_ok}, 32'h1);
    check("rf_new_data", bus.iresp_data, 32'hDEAD_BEEF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
